// File: rtl/branch_predict_unit.sv
// Branch resolver with a direct-mapped BTB of saturating counters: predicts at fetch,
// resolves and trains in EX, flags mispredicts and keeps saturating statistics.
module branch_predict_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              ex_valid,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [31:0]       ex_imm,
    input  logic              ex_branch,
    input  logic              ex_jal,
    input  logic [31:0]       ex_alu_result,
    input  logic              ex_pred_taken,
    input  logic [PC_W-1:0]   ex_pred_target,
    output logic [31:0]       ex_pc_imm,
    output logic [31:0]       ex_pc_four,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] stat_resolved,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0]  CTR_RST  = CTR_WEAK - CTR_W'(1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [PC_W-1:0]  r_target [ENTRIES];
    logic [CTR_W-1:0] r_ctr    [ENTRIES];

    logic [STAT_W-1:0] r_stat_resolved;
    logic [STAT_W-1:0] r_stat_mispred;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;

    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic [CTR_W-1:0] w_ctr_cur;
    logic [CTR_W-1:0] w_ctr_next;

    logic             w_res;
    logic             w_act_taken;
    logic             w_target_wrong;
    logic             w_mispred;

    // Fetch-side lookup reads the table registers directly; no bypass from a same-cycle update.
    assign w_if_idx    = if_pc[IDX_W+1:2];
    assign w_if_tag    = if_pc[PC_W-1:IDX_W+2];
    assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken  = w_if_hit && r_ctr[w_if_idx][CTR_W-1];
    assign pred_target = r_target[w_if_idx];

    assign ex_pc_imm  = 32'(ex_pc) + ex_imm;
    assign ex_pc_four = 32'(ex_pc) + 32'd4;

    assign w_res          = ex_valid && (ex_branch || ex_jal);
    assign w_act_taken    = ex_jal || (ex_branch && ex_alu_result[0]);
    assign w_target_wrong = ex_pred_target != ex_pc_imm[PC_W-1:0];
    assign w_mispred      = w_res && ((w_act_taken != ex_pred_taken) ||
                                      (w_act_taken && ex_pred_taken && w_target_wrong));

    assign redirect    = w_mispred;
    assign redirect_pc = (w_res && w_act_taken) ? ex_pc_imm : ex_pc_four;

    assign w_ex_idx  = ex_pc[IDX_W+1:2];
    assign w_ex_tag  = ex_pc[PC_W-1:IDX_W+2];
    assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_ctr_cur = r_ctr[w_ex_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (ex_jal) begin
            w_ctr_next = CTR_MAX;
        end else if (!w_ex_hit) begin
            w_ctr_next = CTR_WEAK;
        end else if (w_act_taken) begin
            w_ctr_next = (w_ctr_cur == CTR_MAX) ? CTR_MAX : w_ctr_cur + CTR_W'(1);
        end else begin
            w_ctr_next = (w_ctr_cur == '0) ? '0 : w_ctr_cur - CTR_W'(1);
        end
    end

    // A taken outcome (re)writes the whole entry, which covers both allocation and hit-training;
    // a not-taken outcome only ever touches the counter of an existing entry.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_valid[gi]  <= 1'b0;
                    r_tag[gi]    <= '0;
                    r_target[gi] <= '0;
                    r_ctr[gi]    <= CTR_RST;
                end else if (w_res && (w_ex_idx == IDX_W'(gi))) begin
                    if (w_act_taken) begin
                        r_valid[gi]  <= 1'b1;
                        r_tag[gi]    <= w_ex_tag;
                        r_target[gi] <= ex_pc_imm[PC_W-1:0];
                        r_ctr[gi]    <= w_ctr_next;
                    end else if (w_ex_hit) begin
                        r_ctr[gi]    <= w_ctr_next;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_resolved <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (w_res && (r_stat_resolved != STAT_MAX))
                r_stat_resolved <= r_stat_resolved + STAT_W'(1);
            if (w_mispred && (r_stat_mispred != STAT_MAX))
                r_stat_mispred <= r_stat_mispred + STAT_W'(1);
        end
    end

    assign stat_resolved = r_stat_resolved;
    assign stat_mispred  = r_stat_mispred;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: resolve arithmetic, BTB training/aliasing,
// saturating statistics (narrow STAT_W) and asynchronous reset mid-stream.
module tb_branch_predict_unit;

    localparam int PC_W   = 9;
    localparam int STAT_W = 4;

    logic              clk;
    logic              reset;
    logic [PC_W-1:0]   if_pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic [31:0]       ex_imm;
    logic              ex_branch;
    logic              ex_jal;
    logic [31:0]       ex_alu_result;
    logic              ex_pred_taken;
    logic [PC_W-1:0]   ex_pred_target;
    logic [31:0]       ex_pc_imm;
    logic [31:0]       ex_pc_four;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [STAT_W-1:0] stat_resolved;
    logic [STAT_W-1:0] stat_mispred;

    int n_tests = 0;
    int n_fail  = 0;

    branch_predict_unit #(
        .PC_W(PC_W), .ENTRIES(16), .CTR_W(2), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_alu_result(ex_alu_result),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_pc_imm(ex_pc_imm), .ex_pc_four(ex_pc_four),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic [PC_W-1:0] pc, input logic [31:0] imm,
                          input logic br, input logic jal, input logic alu0,
                          input logic pt, input logic [PC_W-1:0] ptg);
        ex_valid       = v;
        ex_pc          = pc;
        ex_imm         = imm;
        ex_branch      = br;
        ex_jal         = jal;
        ex_alu_result  = {31'd0, alu0};
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
        #1;
        $display("[TB] ex v=%0b pc=0x%0h imm=0x%0h br=%0b jal=%0b c=%0b pt=%0b ptg=0x%0h -> redirect=%0b pc=0x%0h",
                 v, pc, imm, br, jal, alu0, pt, ptg, redirect, redirect_pc);
    endtask

    task automatic ex_clear();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_jal = 1'b0;
        ex_alu_result = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    endtask

    task automatic lookup(input string tag, input logic [PC_W-1:0] pc,
                          input logic exp_t, input logic [PC_W-1:0] exp_tg, input logic chk_tg);
        if_pc = pc;
        #1;
        check({tag, ".taken"}, 32'(pred_taken), 32'(exp_t));
        if (chk_tg) check({tag, ".target"}, 32'(pred_target), 32'(exp_tg));
    endtask

    initial begin
        ex_clear();
        ex_pc = '0; ex_imm = '0; if_pc = 9'h010;
        reset = 1'b1;
        #1;
        check("rst_held.pred_taken", 32'(pred_taken), 32'd0);
        check("rst_held.pred_target", 32'(pred_target), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        lookup("reset_miss", 9'h010, 1'b0, 9'h000, 1'b1);
        check("reset.stat_resolved", 32'(stat_resolved), 32'd0);
        check("reset.stat_mispred", 32'(stat_mispred), 32'd0);

        // Address arithmetic with a negative immediate; invalid slot never redirects.
        ex_set(1'b0, 9'h020, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000);
        check("neg_imm.pc_imm", ex_pc_imm, 32'h18);
        check("neg_imm.pc_four", ex_pc_four, 32'h24);
        check("invalid.redirect", 32'(redirect), 32'd0);
        check("invalid.redirect_pc", redirect_pc, 32'h24);

        // Taken branch at 0x40, predicted not-taken: mispredict and allocate (ctr=2).
        if_pc = 9'h040;
        ex_set(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000);
        check("br_taken.redirect", 32'(redirect), 32'd1);
        check("br_taken.redirect_pc", redirect_pc, 32'h60);
        check("no_bypass.pred_taken", 32'(pred_taken), 32'd0);
        tick(); ex_clear();
        lookup("alloc_40", 9'h040, 1'b1, 9'h060, 1'b1);
        check("stat1.resolved", 32'(stat_resolved), 32'd1);
        check("stat1.mispred", 32'(stat_mispred), 32'd1);

        // Not taken, predicted taken: mispredict, ctr 2->1.
        ex_set(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 9'h060);
        check("nt1.redirect", 32'(redirect), 32'd1);
        check("nt1.redirect_pc", redirect_pc, 32'h44);
        tick(); ex_clear();
        lookup("nt1_lookup", 9'h040, 1'b0, 9'h060, 1'b1);

        // Not taken, predicted not-taken: correct, ctr 1->0.
        ex_set(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
        check("nt2.redirect", 32'(redirect), 32'd0);
        check("nt2.redirect_pc", redirect_pc, 32'h44);
        tick();
        // Third not-taken must hold ctr at 0, so one taken only reaches 1 (still not-taken).
        ex_set(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
        tick();
        ex_set(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000);
        check("retake.redirect", 32'(redirect), 32'd1);
        tick(); ex_clear();
        lookup("ctr_floor", 9'h040, 1'b0, 9'h060, 1'b1);
        check("stat5.resolved", 32'(stat_resolved), 32'd5);
        check("stat5.mispred", 32'(stat_mispred), 32'd3);

        // JAL predicted with the right target: no redirect; allocates with ctr=3.
        ex_set(1'b1, 9'h008, 32'h10, 1'b0, 1'b1, 1'b0, 1'b1, 9'h018);
        check("jal_ok.redirect", 32'(redirect), 32'd0);
        check("jal_ok.redirect_pc", redirect_pc, 32'h18);
        tick();
        ex_set(1'b1, 9'h008, 32'h10, 1'b0, 1'b1, 1'b0, 1'b1, 9'h01C);
        check("jal_badtgt.redirect", 32'(redirect), 32'd1);
        check("jal_badtgt.redirect_pc", redirect_pc, 32'h18);
        tick(); ex_clear();
        lookup("jal_alloc", 9'h008, 1'b1, 9'h018, 1'b1);
        // A not-taken branch at the JAL entry: 3->2, still predicted taken.
        ex_set(1'b1, 9'h008, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 9'h018);
        tick(); ex_clear();
        lookup("jal_strong", 9'h008, 1'b1, 9'h018, 1'b1);
        check("stat8.resolved", 32'(stat_resolved), 32'd8);
        check("stat8.mispred", 32'(stat_mispred), 32'd5);

        // Aliasing: 0x140 shares index 0 with 0x040 but has a different tag.
        ex_set(1'b1, 9'h140, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000);
        tick(); ex_clear();
        lookup("alias_old", 9'h040, 1'b0, 9'h000, 1'b0);
        lookup("alias_new", 9'h140, 1'b1, 9'h150, 1'b1);

        // Not-taken miss at 0x100 (index 0): mispredict, but the table is untouched.
        for (int i = 0; i < 8; i++) begin
            ex_set(1'b1, 9'h100, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 9'h110);
            tick();
        end
        ex_clear();
        lookup("miss_nt_no_alloc", 9'h140, 1'b1, 9'h150, 1'b1);
        check("sat.resolved", 32'(stat_resolved), 32'd15);
        check("stat14.mispred", 32'(stat_mispred), 32'd14);
        for (int i = 0; i < 2; i++) begin
            ex_set(1'b1, 9'h100, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 9'h110);
            tick();
        end
        ex_clear();
        #1;
        check("sat.mispred", 32'(stat_mispred), 32'd15);
        check("sat_hold.resolved", 32'(stat_resolved), 32'd15);

        // Asynchronous reset mid-cycle with a live mispredict in EX.
        ex_set(1'b1, 9'h100, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 9'h110);
        #2 reset = 1'b1;
        lookup("midrst_jal", 9'h008, 1'b0, 9'h000, 1'b1);
        lookup("midrst_alias", 9'h140, 1'b0, 9'h000, 1'b1);
        check("midrst.stat_resolved", 32'(stat_resolved), 32'd0);
        check("midrst.stat_mispred", 32'(stat_mispred), 32'd0);
        check("midrst.redirect", 32'(redirect), 32'd1);
        check("midrst.redirect_pc", redirect_pc, 32'h104);
        tick();
        ex_clear();
        reset = 1'b0;
        tick();
        lookup("post_rst_jal", 9'h008, 1'b0, 9'h000, 1'b1);
        lookup("post_rst_40", 9'h040, 1'b0, 9'h000, 1'b1);
        check("post_rst.stat_resolved", 32'(stat_resolved), 32'd0);
        check("post_rst.stat_mispred", 32'(stat_mispred), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
